// File: rtl/capture_if.sv
// Capture sequencer bundle: sample strobe, run/trigger controls, RAM write port and status.
// The master side drives the controls; the slave side is the capture controller.
interface capture_if #(
    parameter int ADDR_W = 9
);
    logic              wrt_smpl;
    logic              run;
    logic              protTrig;
    logic              chTrig;
    logic [ADDR_W-1:0] trig_pos;
    logic              done_clr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              triggered;
    logic              capture_done;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] rd_start;
    logic              auto_trig;

    modport master (
        output wrt_smpl, run, protTrig, chTrig, trig_pos, done_clr,
        input  we, waddr, triggered, capture_done, trig_addr, rd_start, auto_trig
    );

    modport slave (
        input  wrt_smpl, run, protTrig, chTrig, trig_pos, done_clr,
        output we, waddr, triggered, capture_done, trig_addr, rd_start, auto_trig
    );
endinterface

// File: rtl/capture_ctrl.sv
// Circular-buffer capture sequencer: pre-trigger fill, armed wait, post-trigger count, done hold.
// Optional forced trigger after a quiet ARMED period when CAP_AUTO_TRIG_EN is defined.
module capture_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int AUTO_CNT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    capture_if.slave  bus
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0]     DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CW-1:0]     CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] waddr_r;
    logic [ADDR_W-1:0] trig_addr_r;
    logic [ADDR_W-1:0] rd_start_r;
    logic [CW-1:0]     smpl_cnt_r;
    logic [CW-1:0]     post_cnt_r;
    logic [CW-1:0]     pre_r;
    logic [CW-1:0]     post_r;
    logic              triggered_r;
    logic              capture_done_r;

    logic              trig_s;
    logic              force_s;
    logic              trig_hit_s;
    logic [ADDR_W-1:0] tp_eff_s;
    logic [CW-1:0]     post_len_s;
    logic              fill_end_s;
    logic              post_end_s;
    logic              we_s;
    logic              start_s;
    logic              arm_trig_s;
    logic              finish_s;
    logic              abort_s;
    logic              release_s;

    assign trig_s     = bus.protTrig & bus.chTrig;
    assign trig_hit_s = trig_s | force_s;
    assign tp_eff_s   = (bus.trig_pos == '0) ? ADDR_ONE : bus.trig_pos;
    assign post_len_s = {1'b0, tp_eff_s};
    assign fill_end_s = (state_r == FILL) & bus.wrt_smpl & ((smpl_cnt_r + CNT_ONE) == pre_r);
    assign post_end_s = (state_r == POST) & bus.wrt_smpl & ((post_cnt_r + CNT_ONE) == post_r);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping run aborts any active capture
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_nxt_s = FILL;
                else         state_nxt_s = IDLE;
            end
            FILL: begin
                if (!bus.run)        state_nxt_s = IDLE;
                else if (fill_end_s) state_nxt_s = ARMED;
                else                 state_nxt_s = FILL;
            end
            ARMED: begin
                if (!bus.run)        state_nxt_s = IDLE;
                else if (finish_s)   state_nxt_s = DONE;
                else if (arm_trig_s) state_nxt_s = POST;
                else                 state_nxt_s = ARMED;
            end
            POST: begin
                if (!bus.run)      state_nxt_s = IDLE;
                else if (finish_s) state_nxt_s = DONE;
                else               state_nxt_s = POST;
            end
            DONE: begin
                if (release_s) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state strobes; a trigger coincident with the write of a 1-sample post window finishes at once
    always_comb begin
        we_s       = 1'b0;
        start_s    = 1'b0;
        arm_trig_s = 1'b0;
        finish_s   = 1'b0;
        abort_s    = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            IDLE: begin
                start_s = bus.run & ~capture_done_r;
            end
            FILL: begin
                we_s    = bus.wrt_smpl;
                abort_s = ~bus.run;
            end
            ARMED: begin
                we_s       = bus.wrt_smpl;
                abort_s    = ~bus.run;
                arm_trig_s = bus.run & trig_hit_s;
                finish_s   = bus.run & trig_hit_s & bus.wrt_smpl & (post_r == CNT_ONE);
            end
            POST: begin
                we_s     = bus.wrt_smpl;
                abort_s  = ~bus.run;
                finish_s = bus.run & post_end_s;
            end
            DONE: begin
                release_s = bus.done_clr;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Circular write address, restarted from 0 on every new capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_r <= '0;
        end else if (state_r == IDLE) begin
            waddr_r <= '0;
        end else if (we_s) begin
            waddr_r <= waddr_r + ADDR_ONE;
        end
    end

    // Pre/post window lengths, frozen at capture start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r  <= '0;
            post_r <= '0;
        end else if (start_s) begin
            pre_r  <= DEPTH_C - post_len_s;
            post_r <= post_len_s;
        end
    end

    // Pre-trigger and post-trigger sample counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_cnt_r <= '0;
            post_cnt_r <= '0;
        end else begin
            if (state_r == IDLE) begin
                smpl_cnt_r <= '0;
            end else if ((state_r == FILL) && we_s) begin
                smpl_cnt_r <= smpl_cnt_r + CNT_ONE;
            end
            if (state_r == IDLE) begin
                post_cnt_r <= '0;
            end else if (arm_trig_s) begin
                post_cnt_r <= {{ADDR_W{1'b0}}, bus.wrt_smpl};
            end else if ((state_r == POST) && we_s) begin
                post_cnt_r <= post_cnt_r + CNT_ONE;
            end
        end
    end

    // Trigger and completion status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            triggered_r    <= 1'b0;
            trig_addr_r    <= '0;
            capture_done_r <= 1'b0;
            rd_start_r     <= '0;
        end else begin
            if (arm_trig_s) begin
                triggered_r <= 1'b1;
                trig_addr_r <= waddr_r;
            end else if (abort_s || release_s || (state_r == IDLE)) begin
                triggered_r <= 1'b0;
            end
            if (finish_s) begin
                capture_done_r <= 1'b1;
                rd_start_r     <= waddr_r + ADDR_ONE;
            end else if (release_s) begin
                capture_done_r <= 1'b0;
            end
        end
    end

`ifdef CAP_AUTO_TRIG_EN
    localparam logic [AUTO_CNT-1:0] AUTO_MAX = {AUTO_CNT{1'b1}};
    logic [AUTO_CNT-1:0] auto_cnt_r;
    logic                auto_trig_r;

    assign force_s = (state_r == ARMED) & (auto_cnt_r == AUTO_MAX) & ~trig_s;

    // Quiet-period counter: only runs in ARMED, saturates at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_r <= '0;
        end else if (state_r != ARMED) begin
            auto_cnt_r <= '0;
        end else if (we_s && (auto_cnt_r != AUTO_MAX)) begin
            auto_cnt_r <= auto_cnt_r + {{(AUTO_CNT-1){1'b0}}, 1'b1};
        end
    end

    // Forced-trigger flag follows the lifetime of triggered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_trig_r <= 1'b0;
        end else if (arm_trig_s) begin
            auto_trig_r <= force_s;
        end else if (abort_s || release_s || (state_r == IDLE)) begin
            auto_trig_r <= 1'b0;
        end
    end

    assign bus.auto_trig = auto_trig_r;
`else
    assign force_s       = 1'b0;
    assign bus.auto_trig = 1'b0 & (AUTO_CNT > 32'sd0);
`endif

    assign bus.we           = we_s;
    assign bus.waddr        = waddr_r;
    assign bus.triggered    = triggered_r;
    assign bus.capture_done = capture_done_r;
    assign bus.trig_addr    = trig_addr_r;
    assign bus.rd_start     = rd_start_r;
endmodule
